// File: rtl/cam_soc_pio_pkg.sv
// cam_soc_pio_pkg
// Shared definitions for the camera SoC parallel I/O ports.
//   pio_reg_e    : word offsets of the PIO register map
//   EDGE_*       : edge-type selector values for the key input port
//   edge_select  : picks the capture condition for one bit from its
//                  rise/fall pulses according to the edge type
package cam_soc_pio_pkg;

  typedef enum logic [1:0] {
    PIO_DATA         = 2'd0,
    PIO_RESERVED     = 2'd1,
    PIO_IRQ_MASK     = 2'd2,
    PIO_EDGE_CAPTURE = 2'd3
  } pio_reg_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic logic edge_select(input int edge_type, input logic rise, input logic fall);
    logic hit;
    case (edge_type)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      default:   hit = rise | fall;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/cam_soc_debounce.sv
// cam_soc_debounce
// Single-bit two-flop synchroniser followed by a counter debouncer.
// A new level is accepted only after it has disagreed with the held
// level for DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   pin          : asynchronous input pin
//   stable       : debounced level
//   rise, fall   : one-cycle pulses, asserted during the cycle whose
//                  closing edge updates stable (combinational, so the
//                  consumer can latch them at that same edge)
module cam_soc_debounce #(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic [CW-1:0] cnt_reg;
  logic          accept;

  // The mismatch has persisted long enough: this edge takes the new level.
  assign accept = (sync2_reg != stable_reg) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg  <= RESET_LEVEL;
      sync2_reg  <= RESET_LEVEL;
      stable_reg <= RESET_LEVEL;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= pin;
      sync2_reg <= sync1_reg;
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (accept) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign stable = stable_reg;
  assign rise   = accept & sync2_reg;
  assign fall   = accept & ~sync2_reg;

endmodule

// File: rtl/cam_soc_key_pio.sv
// cam_soc_key_pio
// Avalon-MM slave input port for push-buttons/switches. Each pin is
// synchronised and debounced; selected edges latch into EDGE_CAPTURE
// and raise a level interrupt when unmasked.
// Register map (word offsets): 0 DATA (ro), 1 reads 0, 2 IRQ_MASK (rw),
// 3 EDGE_CAPTURE (read, write-1-to-clear). Read latency 1, no wait states.
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata        : Avalon-MM slave request
//   readdata                  : registered read data
//   in_port                   : asynchronous pin inputs
//   irq                       : registered level interrupt
module cam_soc_key_pio
  import cam_soc_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 2,
  parameter int RESET_LEVEL     = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] fall_vec;
  logic [WIDTH-1:0] set_vec;
  logic [WIDTH-1:0] clr_vec;
  logic [WIDTH-1:0] edge_capture_reg;
  logic [WIDTH-1:0] irq_mask_reg;
  logic [31:0]      read_value;
  logic             wr_en;
  logic             rd_en;
  logic             unused_writedata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      cam_soc_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (RESET_LEVEL != 0)
      ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .pin    (in_port[gi]),
        .stable (level[gi]),
        .rise   (rise_vec[gi]),
        .fall   (fall_vec[gi])
      );
      assign set_vec[gi] = edge_select(EDGE_TYPE, rise_vec[gi], fall_vec[gi]);
    end
  endgenerate

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & write_n;
  assign clr_vec = (wr_en && address == PIO_EDGE_CAPTURE) ? writedata[WIDTH-1:0] : '0;

  // Upper write-data bits have no destination when WIDTH < 32.
  assign unused_writedata = ^writedata;

  always_comb begin
    read_value = '0;
    case (pio_reg_e'(address))
      PIO_DATA:         read_value[WIDTH-1:0] = level;
      PIO_IRQ_MASK:     read_value[WIDTH-1:0] = irq_mask_reg;
      PIO_EDGE_CAPTURE: read_value[WIDTH-1:0] = edge_capture_reg;
      default:          read_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata         <= '0;
      irq              <= 1'b0;
      edge_capture_reg <= '0;
      irq_mask_reg     <= '0;
    end else begin
      if (rd_en) begin
        readdata <= read_value;
      end
      if (wr_en && address == PIO_IRQ_MASK) begin
        irq_mask_reg <= writedata[WIDTH-1:0];
      end
      // Clear first, then OR in new edges: a simultaneous set wins.
      edge_capture_reg <= (edge_capture_reg & ~clr_vec) | set_vec;
      irq              <= |(edge_capture_reg & irq_mask_reg);
    end
  end

endmodule

// File: tb/tb_cam_soc_key_pio.sv
// tb_cam_soc_key_pio
// Directed bench for cam_soc_key_pio. Two instances share the bus:
// dut (EDGE_TYPE any) and dut_fall (EDGE_TYPE falling), both with
// WIDTH=4, DEBOUNCE_CYCLES=4, RESET_LEVEL=0.
module tb_cam_soc_key_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] readdata2;
  logic [3:0]  in_port;
  logic [3:0]  in_port2;
  logic        irq;
  logic        irq2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cam_soc_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .RESET_LEVEL(0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  cam_soc_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .RESET_LEVEL(0)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata2),
    .in_port(in_port2), .irq(irq2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s value=0x%08h", tag, got);
    end
  endtask

  // Write: request driven after an edge, takes effect at the next edge;
  // returns 1ns after that write edge.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    chipselect = 1'b1; write_n = 1'b0; address = addr; writedata = data;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] d, output logic [31:0] d2);
    @(posedge clk); #1;
    chipselect = 1'b1; write_n = 1'b1; address = addr;
    @(posedge clk); #1;
    chipselect = 1'b0;
    d  = readdata;
    d2 = readdata2;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, rd2;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
    writedata = '0; in_port = '0; in_port2 = '0;

    // Reset held while pins toggle.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_port = 4'(i * 5); in_port2 = 4'(i * 3);
    end
    @(negedge clk);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    in_port = '0; in_port2 = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    bus_read(2'd0, rd, rd2);
    check("post_reset_data", rd, 32'h0);
    bus_read(2'd3, rd, rd2);
    check("post_reset_capture", rd, 32'h0);
    bus_read(2'd1, rd, rd2);
    check("offset1_reads_zero", rd, 32'h0);

    // Glitch on bit1: three clocks in sync2, must be rejected.
    bus_write(2'd2, 32'h2);
    in_port = 4'h2;
    repeat (3) @(posedge clk);
    #1 in_port = 4'h0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("glitch_irq", {31'b0, irq}, 32'h0);
    bus_read(2'd0, rd, rd2);
    check("glitch_data", rd, 32'h0);
    bus_read(2'd3, rd, rd2);
    check("glitch_capture", rd, 32'h0);

    // Clean rise on bit0, exact latency: edge k is the next edge.
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, rd, rd2);
    check("mask_readback", rd, 32'h1);
    chipselect = 1'b1; write_n = 1'b1; address = 2'd3;
    in_port = 4'h1;
    @(posedge clk);                 // edge k
    repeat (4) @(posedge clk);      // edge k+4
    @(negedge clk);
    check("rise_irq_k4", {31'b0, irq}, 32'h0);
    @(posedge clk);                 // edge k+5: capture sets
    @(negedge clk);
    check("rise_irq_k5", {31'b0, irq}, 32'h0);
    check("rise_rd_k5", readdata, 32'h0);
    @(posedge clk);                 // edge k+6: irq asserts
    @(negedge clk);
    check("rise_irq_k6", {31'b0, irq}, 32'h1);
    check("rise_rd_k6", readdata, 32'h1);
    chipselect = 1'b0;
    bus_read(2'd0, rd, rd2);
    check("rise_data", rd, 32'h1);

    // Bit2 rise, then W1C behaviour.
    in_port = 4'h5;
    repeat (10) @(posedge clk);
    bus_read(2'd3, rd, rd2);
    check("capture_0x5", rd, 32'h5);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, rd, rd2);
    check("w1c_bit2", rd, 32'h1);
    check("w1c_irq_still", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    @(negedge clk);
    check("w1c_irq_write_edge", {31'b0, irq}, 32'h1);
    @(negedge clk);
    check("w1c_irq_dropped", {31'b0, irq}, 32'h0);
    bus_read(2'd3, rd, rd2);
    check("w1c_all_clear", rd, 32'h0);
    bus_write(2'd0, 32'hF);
    bus_read(2'd0, rd, rd2);
    check("data_write_ignored", rd, 32'h5);

    // Collision: W1C of bit0 at the same edge a bit0 fall is captured.
    @(posedge clk); #1;
    in_port = 4'h4;
    @(posedge clk);                 // edge k
    repeat (4) @(posedge clk);      // edge k+4
    #1;
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h1;
    @(posedge clk);                 // edge k+5: set and clear together
    #1 chipselect = 1'b0; write_n = 1'b1;
    bus_read(2'd3, rd, rd2);
    check("collision_set_wins", rd, 32'h1);

    // Masking.
    bus_write(2'd2, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("mask0_irq", {31'b0, irq}, 32'h0);
    bus_write(2'd2, 32'hF);
    @(negedge clk);
    check("maskF_irq_write_edge", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("maskF_irq_next", {31'b0, irq}, 32'h1);

    // Falling-edge instance: rise ignored, fall captured.
    @(posedge clk); #1;
    in_port2 = 4'h2;
    repeat (10) @(posedge clk);
    bus_read(2'd3, rd, rd2);
    check("fall_on_rise_capture", rd2, 32'h0);
    bus_read(2'd0, rd, rd2);
    check("fall_data_high", rd2, 32'h2);
    @(negedge clk);
    check("fall_on_rise_irq", {31'b0, irq2}, 32'h0);
    @(posedge clk); #1;
    in_port2 = 4'h0;
    repeat (10) @(posedge clk);
    bus_read(2'd3, rd, rd2);
    check("fall_capture", rd2, 32'h2);
    @(negedge clk);
    check("fall_irq", {31'b0, irq2}, 32'h1);

    // Asynchronous reset mid-operation.
    bus_read(2'd3, rd, rd2);
    check("pre_reset_rd", rd, 32'h1);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_irq", {31'b0, irq}, 32'h0);
    check("async_reset_readdata", readdata, 32'h0);
    check("async_reset_irq2", {31'b0, irq2}, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    in_port = '0;
    bus_read(2'd3, rd, rd2);
    check("after_reset_capture", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
